// File: rtl/mem_responder.sv
// Word-addressed memory responder with fixed first-access latency and a shorter
// latency for sequential beats. Define MEM_RESPONDER_ERR_EN to add out-of-range error reporting.
module mem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int LATENCY     = 4,
    parameter int SEQ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic                  mem_read,
    input  logic                  mem_write,
    output logic                  mem_ready,
`ifdef MEM_RESPONDER_ERR_EN
    output logic                  mem_err,
`endif
    output logic [1:0]            dbg_state
);

    // Handshake: mem_read/mem_write are levels held by the requester until
    // mem_ready pulses for one cycle; dropping both while waiting aborts the beat.

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESPOND = 2'd2
    } state_e;

    localparam int BYTE_SH = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W   = $clog2(MEM_DEPTH);
    localparam int CNT_W   = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] SEQ_LOAD = CNT_W'(SEQ_LATENCY - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    wr_q, wr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    seq_ok_q, seq_ok_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

    logic                    req;
    logic [ADDR_WIDTH-1:0]   req_word;
    logic                    is_seq;
    logic                    wait_done;
    logic                    oob;
    logic                    mem_we;
    logic [IDX_W-1:0]        idx;

    assign req      = mem_read | mem_write;
    assign req_word = mem_addr >> BYTE_SH;
    assign idx      = addr_q[IDX_W-1:0];

`ifdef MEM_RESPONDER_ERR_EN
    assign oob = |addr_q[ADDR_WIDTH-1:IDX_W];
`else
    assign oob = 1'b0;
`endif

    // A beat is sequential only when accepted in the first IDLE cycle after a response.
    assign is_seq    = seq_ok_q && (mem_write == wr_q) && (req_word == addr_q + ADDR_WIDTH'(1));
    assign wait_done = (state_q == S_WAIT) && req && (cnt_q == '0);
    assign mem_we    = wait_done && wr_q && !oob;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (req) state_d = S_WAIT;
            S_WAIT: begin
                if (!req)               state_d = S_IDLE;
                else if (cnt_q == '0)   state_d = S_RESPOND;
            end
            S_RESPOND: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_ready = (state_q == S_RESPOND);
`ifdef MEM_RESPONDER_ERR_EN
        mem_err   = (state_q == S_RESPOND) && oob;
`endif
        dbg_state = state_q;
    end

    always_comb begin
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wr_d     = wr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        seq_ok_d = (state_q == S_RESPOND);
        if (state_q == S_IDLE && req) begin
            cnt_d   = is_seq ? SEQ_LOAD : LAT_LOAD;
            addr_d  = req_word;
            wr_d    = mem_write;
            wdata_d = mem_data_out;
        end else if (state_q == S_WAIT) begin
            if (!req)               cnt_d = '0;
            else if (cnt_q != '0)   cnt_d = cnt_q - CNT_W'(1);
        end
        // Write responses and out-of-range reads return zero.
        if (wait_done) begin
            rdata_d = (wr_q || oob) ? '0 : mem_q[idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            seq_ok_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            wdata_q  <= wdata_d;
            seq_ok_q <= seq_ok_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage has no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= wdata_q;
        end
    end

    assign mem_data_in = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: latency, sequential bursts, abort, reset
// mid-access, read+write collision and address range handling.
module tb_mem_responder;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_out;
    logic [31:0] mem_data_in;
    logic        mem_read;
    logic        mem_write;
    logic        mem_ready;
    logic [1:0]  dbg_state;
`ifdef MEM_RESPONDER_ERR_EN
    logic        mem_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mem_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_addr     (mem_addr),
        .mem_data_out (mem_data_out),
        .mem_data_in  (mem_data_in),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_ready    (mem_ready),
`ifdef MEM_RESPONDER_ERR_EN
        .mem_err      (mem_err),
`endif
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drives one beat from a negedge with the FSM in IDLE; returns at the negedge
    // after the response has ended, so a following call is back-to-back.
    task automatic do_access(input string tag, input bit rd, input bit wr,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int exp_lat, input bit chk_data,
                             input logic [31:0] exp_data, input bit hold);
        int cyc;
        bit got;
`ifdef MEM_RESPONDER_ERR_EN
        logic err_seen;
        err_seen = 1'b0;
`endif
        mem_read     = rd;
        mem_write    = wr;
        mem_addr     = addr;
        mem_data_out = wdata;
        cyc = 0;
        got = 0;
        while (!got && cyc < 20) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (mem_ready) begin
                got = 1;
`ifdef MEM_RESPONDER_ERR_EN
                err_seen = mem_err;
`endif
            end else begin
                mem_addr     = $urandom;
                mem_data_out = $urandom;
            end
        end
        check_eq({tag, "_lat"}, 32'(cyc - 1), 32'(exp_lat));
        if (chk_data) check_eq({tag, "_data"}, mem_data_in, exp_data);
`ifdef MEM_RESPONDER_ERR_EN
        check_eq({tag, "_err"}, {31'd0, err_seen}, {31'd0, (addr >> 2) >= 32'd1024});
`endif
        if (!hold) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_pulse"}, {31'd0, mem_ready}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen_ready;

        rst_n        = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = '0;
        mem_data_out = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", {31'd0, mem_ready}, 32'd0);
        check_eq("rst_data", mem_data_in, 32'd0);
        check_eq("rst_state", {30'd0, dbg_state}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_access("wr_40", 0, 1, 32'h40, 32'hDEADBEEF, 4, 1, 32'h0, 0);
        do_access("rd_40", 1, 0, 32'h40, 32'h0, 4, 1, 32'hDEADBEEF, 0);
        do_access("rd_43", 1, 0, 32'h43, 32'h0, 4, 1, 32'hDEADBEEF, 0);
        check_eq("hold_data", mem_data_in, 32'hDEADBEEF);

        for (int i = 0; i < 8; i++)
            do_access($sformatf("pre%0d", i), 0, 1, 32'h100 + 32'(4 * i), 32'h40 + 32'(i),
                      (i == 0) ? 4 : 1, 1, 32'h0, 0);
        for (int i = 0; i < 8; i++)
            do_access($sformatf("burst%0d", i), 1, 0, 32'h100 + 32'(4 * i), 32'h0,
                      (i == 0) ? 4 : 1, 1, 32'h40 + 32'(i), i < 7);

        do_access("rd_200", 1, 0, 32'h200, 32'h0, 4, 0, 32'h0, 0);
        do_access("rd_300", 1, 0, 32'h300, 32'h0, 4, 0, 32'h0, 0);

        do_access("wr_80", 0, 1, 32'h80, 32'h12345678, 4, 1, 32'h0, 0);
        mem_write    = 1'b1;
        mem_addr     = 32'h80;
        mem_data_out = 32'hBADBAD00;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        mem_write  = 1'b0;
        seen_ready = 1'b0;
        repeat (8) begin
            @(posedge clk); @(negedge clk);
            if (mem_ready) seen_ready = 1'b1;
        end
        check_eq("abort_ready", {31'd0, seen_ready}, 32'd0);
        check_eq("abort_state", {30'd0, dbg_state}, 32'd0);
        do_access("rd_80", 1, 0, 32'h80, 32'h0, 4, 1, 32'h12345678, 0);

        do_access("wr_10", 0, 1, 32'h10, 32'h5A5A5A5A, 4, 1, 32'h0, 0);
        do_access("rd_10", 1, 0, 32'h10, 32'h0, 4, 1, 32'h5A5A5A5A, 0);
        mem_write    = 1'b1;
        mem_addr     = 32'h10;
        mem_data_out = 32'hFFFFFFFF;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        rst_n     = 1'b0;
        mem_write = 1'b0;
        #1;
        check_eq("rstw_ready", {31'd0, mem_ready}, 32'd0);
        check_eq("rstw_data", mem_data_in, 32'd0);
        repeat (2) @(negedge clk);
        rst_n      = 1'b1;
        seen_ready = 1'b0;
        repeat (6) begin
            @(posedge clk); @(negedge clk);
            if (mem_ready) seen_ready = 1'b1;
        end
        check_eq("rstw_noready", {31'd0, seen_ready}, 32'd0);
        do_access("rd_10b", 1, 0, 32'h10, 32'h0, 4, 1, 32'h5A5A5A5A, 0);

        do_access("rdwr_14", 1, 1, 32'h14, 32'h0F0F0F0F, 4, 1, 32'h0, 0);
        do_access("rd_14", 1, 0, 32'h14, 32'h0, 4, 1, 32'h0F0F0F0F, 0);

        do_access("wr_0", 0, 1, 32'h0, 32'hCAFEF00D, 4, 1, 32'h0, 0);
`ifdef MEM_RESPONDER_ERR_EN
        do_access("rd_1000", 1, 0, 32'h1000, 32'h0, 4, 1, 32'h0, 0);
        do_access("wr_1000", 0, 1, 32'h1000, 32'h11111111, 4, 1, 32'h0, 0);
        do_access("rd_0", 1, 0, 32'h0, 32'h0, 4, 1, 32'hCAFEF00D, 0);
`else
        do_access("rd_1000", 1, 0, 32'h1000, 32'h0, 4, 1, 32'hCAFEF00D, 0);
        do_access("wr_1004", 0, 1, 32'h1004, 32'h22222222, 4, 1, 32'h0, 0);
        do_access("rd_4", 1, 0, 32'h4, 32'h0, 4, 1, 32'h22222222, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning data word width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning byte address width.
REQ-003 SHALL have parameter MEM_DEPTH, default 1024, meaning storage depth in words (power of 2).
REQ-004 SHALL have parameter LATENCY, default 4, meaning cycles to first response on a non-sequential access (>=1).
REQ-005 SHALL have parameter SEQ_LATENCY, default 1, meaning cycles to response on a sequential beat (>=1, <=LATENCY).
REQ-006 SHALL have port clk, input, 1, meaning clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, meaning reset, asynchronous, active-low.
REQ-008 SHALL have port mem_addr, input, ADDR_WIDTH, meaning requester byte address.
REQ-009 SHALL have port mem_data_out, input, DATA_WIDTH, meaning write data from requester.
REQ-010 SHALL have port mem_data_in, output, DATA_WIDTH, meaning registered read data to requester.
REQ-011 SHALL have port mem_read, input, 1, meaning read request, level, held until mem_ready.
REQ-012 SHALL have port mem_write, input, 1, meaning write request, level, held until mem_ready.
REQ-013 SHALL have port mem_ready, output, 1, meaning one-cycle completion pulse per beat.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESPOND.
REQ-015 In IDLE, with mem_read or mem_write high at an edge, SHALL latch word address (mem_addr >> log2(DATA_WIDTH/8)), the op, and the write data, load a down-counter with L-1, and go to WAIT. Byte-offset bits are ignored.
REQ-016 L SHALL be SEQ_LATENCY when the access is sequential, otherwise LATENCY.
REQ-017 An access is sequential only if it is accepted on the edge immediately after RESPOND, has the same op, and its word address equals the previous word address + 1 (modulo 2^ADDR_WIDTH).
REQ-018 In WAIT, the counter SHALL decrement each cycle. At zero, the FSM SHALL go to RESPOND. This asserts mem_ready exactly L cycles after the accepting edge.
REQ-019 In RESPOND, mem_ready SHALL be 1 for exactly one cycle. A read SHALL present storage[word] on mem_data_in in the same cycle. A write SHALL commit the latched data to storage on the edge entering RESPOND.
REQ-020 From RESPOND, the FSM SHALL always return to IDLE. Back-to-back beats are therefore accepted on the following IDLE edge, and mem_ready is never high two consecutive cycles.
REQ-021 If mem_read and mem_write both drop at any edge in WAIT, the access SHALL abort: return to IDLE, no storage update, no mem_ready, and sequential tracking cleared.
REQ-022 Changes to mem_addr or mem_data_out during WAIT SHALL be ignored; the latched values are used.
REQ-023 If mem_read and mem_write are both high at acceptance, the access SHALL be treated as a write, and mem_data_in SHALL be 0 at response.
REQ-024 mem_data_in SHALL hold its last value outside RESPOND. For a write response, it SHALL be 0.
REQ-025 Storage SHALL be MEM_DEPTH x DATA_WIDTH.

Reset
REQ-026 rst_n low SHALL force, asynchronously: state IDLE, mem_ready 0, mem_data_in 0, counter 0, sequential tracking cleared, and mem_err 0 when present.
REQ-027 Reset SHALL NOT clear storage contents.
REQ-028 Reset asserted during WAIT SHALL cancel the access with no storage update, and no mem_ready after release until a new acceptance.

Configuration
REQ-029 With macro MEM_RESPONDER_ERR_EN defined, the block SHALL add output port mem_err (1 bit) and apply the following for word address >= MEM_DEPTH:
- mem_err is pulsed together with mem_ready;
- a read returns 0;
- a write is dropped.
REQ-030 Without MEM_RESPONDER_ERR_EN, there SHALL be no mem_err port, and the word address SHALL wrap modulo MEM_DEPTH.

Verification
REQ-031 Write 0xDEADBEEF to 0x40 -> mem_ready high 4 cycles after acceptance, one cycle wide. Then read 0x40 -> mem_data_in=0xDEADBEEF with mem_ready 4 cycles after acceptance.
REQ-032 8-beat read burst from 0x100, address +4 after each mem_ready, mem_read held -> beat 0 at latency 4, beats 1..7 at latency 1 each. Data matches preloaded words 0x40..0x47.
REQ-033 Read 0x200, then read 0x300 on the next edge -> both use latency 4 (non-sequential).
REQ-034 Write to 0x80 with mem_write dropped after 2 cycles -> no mem_ready. Subsequent read of 0x80 returns the prior contents.
REQ-035 Assert rst_n low mid-WAIT on a write to 0x10 -> mem_ready 0, mem_data_in 0, storage at 0x10 unchanged after release.
REQ-036 With MEM_RESPONDER_ERR_EN, read at byte 0x1000 (word 1024, depth 1024) -> mem_err=1 with mem_ready, data 0. Without the macro, the same read returns word 0.
